// File: rtl/uart_receive_param.sv
// rtl/uart_receive_param.sv - parametrised UART receiver with majority voting and a valid/ready holding register
module uart_receive_param #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int HALF       = BIT_PERIOD / 2;
  localparam int PW         = $clog2(BIT_PERIOD);
  localparam int IW         = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t                 state, nxt_state;
  logic                   sync1, din_s;
  logic [PW-1:0]          phase;
  logic [IW-1:0]          bit_idx;
  logic                   samp_a, samp_b;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_bit, ferr_acc;
  logic                   phase_last, at_mid, maj, last_stop, commit;
  logic                   exp_par, perr_now, ferr_now;

  assign phase_last = (phase == PW'(BIT_PERIOD - 1));
  assign at_mid     = (phase == PW'(HALF + 1));
  assign maj        = (samp_a & samp_b) | (samp_a & din_s) | (samp_b & din_s);
  // bit_idx doubles as the stop-bit index once the frame reaches STOP
  assign last_stop  = (STOP_BITS == 1) || (bit_idx == IW'(1));
  assign exp_par    = (PARITY == 2) ? ^shreg : ~(^shreg);
  assign perr_now   = (PARITY != 0) && (par_bit != exp_par);
  assign ferr_now   = ferr_acc | ~maj;

  // Flops reset to idle-high so releasing reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      din_s <= 1'b1;
    end else begin
      sync1 <= din;
      din_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:   if (!din_s) nxt_state = S_START;
      S_START: begin
        if (at_mid && maj)   nxt_state = S_IDLE;
        else if (phase_last) nxt_state = S_DATA;
      end
      S_DATA: begin
        if (phase_last && bit_idx == IW'(DATA_BITS - 1))
          nxt_state = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (phase_last) nxt_state = S_STOP;
      S_STOP: begin
        if (at_mid && last_stop)
          nxt_state = ferr_now ? S_WAIT_HIGH : S_IDLE;
      end
      S_WAIT_HIGH: if (din_s) nxt_state = S_IDLE;
      default:  nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != S_IDLE);
    commit = (state == S_STOP) && at_mid && last_stop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= '0;
      bit_idx  <= '0;
      samp_a   <= 1'b0;
      samp_b   <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
    end else begin
      if (phase == PW'(HALF - 1)) samp_a <= din_s;
      if (phase == PW'(HALF))     samp_b <= din_s;
      if (state == S_IDLE || nxt_state == S_IDLE || nxt_state == S_WAIT_HIGH || phase_last)
        phase <= '0;
      else
        phase <= phase + PW'(1);
      if (state != nxt_state)
        bit_idx <= '0;
      else if (phase_last && (state == S_DATA || state == S_STOP))
        bit_idx <= bit_idx + IW'(1);
      if (state == S_DATA && at_mid)   shreg   <= {maj, shreg[DATA_BITS-1:1]};
      if (state == S_PARITY && at_mid) par_bit <= maj;
      if (state == S_IDLE)                            ferr_acc <= 1'b0;
      else if (state == S_STOP && at_mid && !maj)     ferr_acc <= 1'b1;
    end
  end

  // A commit while the consumer stalls drops the new frame, not the held one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        if (!dout_valid || dout_ready) begin
          dout       <= shreg;
          parity_err <= perr_now;
          frame_err  <= ferr_now;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/uart_receive_param.md
Name: uart_receive_param

Overview:
- Parametrised successor to the lab UART receiver, for the same serial-in datapath.
- Configurable data width, parity mode and stop-bit count.
- Adds an input synchroniser, 3-sample majority voting per bit and glitch rejection on the start bit.
- Delivers each frame through a one-entry valid/ready holding register with parity, framing and overrun reporting.

Parameters:
- INPUT_CLOCK_FREQ, 100_000_000, clock frequency in Hz.
- BAUD_RATE, 9600, line rate. BIT_PERIOD = INPUT_CLOCK_FREQ/BAUD_RATE (integer divide); HALF = BIT_PERIOD/2. BIT_PERIOD >= 8 is required.
- DATA_BITS, 8, data bits per frame, legal 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame, legal 1 or 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- din  in  1  asynchronous serial line, idles high
- dout  out  DATA_BITS  received data, LSB = first bit on the wire
- dout_valid  out  1  holding register full
- dout_ready  in  1  consumer accepts; transfer occurs when dout_valid && dout_ready
- parity_err  out  1  parity mismatch for the frame in the holding register; 0 when PARITY=0
- frame_err  out  1  a stop bit sampled 0 for the frame in the holding register
- overrun  out  1  one-cycle pulse: a completed frame was discarded
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n = 0: dout = 0, dout_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0, state = IDLE, counters = 0, both synchroniser flops = 1 (no false start on release).
  - Reset mid-frame aborts the frame immediately; nothing is delivered.
- Synchroniser: din passes through 2 flops; all logic uses the second flop, din_s.
- Phase counter: counts 0..BIT_PERIOD-1 within each bit, then wraps to 0 and advances the bit.
  - din_s is sampled at phase HALF-1, HALF and HALF+1.
  - The bit value is the majority of the three samples, resolved at phase HALF+1.
- States:
  - IDLE: din_s == 0 → START with phase = 0.
  - START: majority at HALF+1 is 1 → IDLE (glitch rejected). Otherwise stay until phase BIT_PERIOD-1 → DATA, bit index = 0.
  - DATA: each majority is shifted in LSB-first. After bit DATA_BITS-1 completes its period → PARITY if PARITY != 0, else STOP.
  - PARITY: the received bit is compared with the expected bit. Even mode: total ones across data + parity is even. Odd mode: total is odd. After one bit period → STOP.
  - STOP:
    - With STOP_BITS = 2, the first stop bit runs a full period; the second is the last stop bit.
    - On the last stop bit the frame commits at phase HALF+1, without waiting for the period to end, so back-to-back frames resynchronise.
    - frame_err = 1 if any stop-bit majority is 0.
    - Next state: WAIT_HIGH on frame error, else IDLE.
  - WAIT_HIGH: remain until din_s == 1, then IDLE. A held-low break line yields exactly one errored frame.
- Commit (cycle C):
  - Holding register loads dout, parity_err and frame_err; dout_valid = 1 from cycle C+1.
  - A frame with errors is still delivered, with its flags set.
- Holding register:
  - dout, parity_err and frame_err stay stable while dout_valid = 1.
  - Transfer at cycle T with no commit at T: dout_valid = 0 from T+1. dout and the flags keep their last values.
  - Commit at a cycle where dout_valid = 1 and dout_ready = 0: the new frame is discarded, the held frame is kept, overrun = 1 for exactly one cycle.
  - Commit and transfer in the same cycle: the new frame is loaded, dout_valid stays 1, no overrun.
- Latency, din falling edge at the sync input to dout_valid:
  - 2 + (1 + DATA_BITS + (PARITY != 0) + STOP_BITS - 1) × BIT_PERIOD + HALF + 2 cycles.
  - Tolerance of ±1 cycle for synchroniser phase.
- Width rules:
  - Bit index counter width is $clog2(DATA_BITS+1).
  - Phase counter width is $clog2(BIT_PERIOD).
  - No overflow is permitted; counters wrap only under the rules above.

Test Plan:
All tests use INPUT_CLOCK_FREQ = 1_000_000, BAUD_RATE = 100_000, so BIT_PERIOD = 10 and HALF = 5.
- Defaults, frame 0xA5 sent with dout_ready = 1 → dout = 0xA5, one-cycle dout_valid, parity_err = 0, frame_err = 0.
- PARITY = 2, DATA_BITS = 7:
  - 0x35 with parity bit 0 → parity_err = 0.
  - Same data with parity bit 1 → dout = 0x35, parity_err = 1.
- 3-cycle low glitch on idle din → no dout_valid, busy returns to 0 within 7 cycles.
- Separately, a single-cycle inverted spike at mid-bit of data bit 3 in 0x00 → dout = 0x00 (majority vote).
- dout_ready = 0, frames 0x11 then 0x22 → dout stays 0x11, overrun pulses once at the second commit.
- Then dout_ready = 1, frame 0x33 sent, committing in the same cycle as the transfer → dout = 0x33, dout_valid never drops.
- Stop bit forced 0, line held low 50 bit periods, then high, then 0x5A → exactly one frame with frame_err = 1, then 0x5A delivered with no errors.
- rst_n pulsed low during data bit 4 of a frame → all outputs 0 immediately; the next clean frame 0xC3 is received correctly.
